// File: rtl/vga_write_arbiter.sv
// Three-way round-robin arbiter feeding a registered VGA adapter write port.
// Writes are only granted during a short window at the end of each frame-limiter period.
module vga_write_arbiter #(
    parameter int unsigned FRAME_PERIOD = 1700000,
    parameter int unsigned WINDOW       = 1200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [53:0] req_colour,
    output logic [2:0]  req_ready,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [17:0] vga_colour,
    output logic        vga_write,
    output logic        window_open,
    output logic        frame_tick
);
    localparam logic [20:0] Reload = 21'(FRAME_PERIOD - 1);

    logic [20:0] limiter_q, limiter_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [17:0] vga_colour_q;
    logic        vga_write_q;

    logic        gnt_vld;
    logic [1:0]  gnt_idx;
    logic [1:0]  cand1, cand2;
    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [17:0] sel_colour;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Compare at 32 bits so WINDOW may equal the full counter range.
    assign window_open = ({11'd0, limiter_q} < WINDOW);
    assign frame_tick  = (limiter_q == 21'd0);

    assign cand1 = inc3(ptr_q);
    assign cand2 = inc3(cand1);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        if (req_valid[ptr_q]) begin
            gnt_vld = 1'b1;
            gnt_idx = ptr_q;
        end else if (req_valid[cand1]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand1;
        end else if (req_valid[cand2]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand2;
        end
        // Reset suppresses any grant so a requester never loses a pixel to it.
        if (reset || !window_open) begin
            gnt_vld = 1'b0;
        end
    end

    assign req_ready = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;

    always_comb begin
        sel_x      = req_x[7:0];
        sel_y      = req_y[6:0];
        sel_colour = req_colour[17:0];
        case (gnt_idx)
            2'd1: begin
                sel_x      = req_x[15:8];
                sel_y      = req_y[13:7];
                sel_colour = req_colour[35:18];
            end
            2'd2: begin
                sel_x      = req_x[23:16];
                sel_y      = req_y[20:14];
                sel_colour = req_colour[53:36];
            end
            default: ;
        endcase
    end

    always_comb begin
        limiter_d = (limiter_q == 21'd0) ? Reload : limiter_q - 21'd1;
        ptr_d     = gnt_vld ? inc3(gnt_idx) : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            limiter_q    <= Reload;
            ptr_q        <= 2'd0;
            vga_write_q  <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 18'd0;
        end else begin
            limiter_q    <= limiter_d;
            ptr_q        <= ptr_d;
            vga_write_q  <= gnt_vld;
            vga_x_q      <= gnt_vld ? sel_x : 8'd0;
            vga_y_q      <= gnt_vld ? sel_y : 7'd0;
            vga_colour_q <= gnt_vld ? sel_colour : 18'd0;
        end
    end

    assign vga_write  = vga_write_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Randomised scoreboard bench for vga_write_arbiter: a frame-phase/rotation model predicts
// grants and pixels, and a separate monitor matches every emitted VGA write.
module tb_vga_write_arbiter;
    localparam int FP  = 20;
    localparam int WIN = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [53:0] req_colour;
    logic [2:0]  req_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;
    logic        window_open;
    logic        frame_tick;

    vga_write_arbiter #(
        .FRAME_PERIOD(FP),
        .WINDOW      (WIN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_write  (vga_write),
        .window_open(window_open),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [17:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   mode  = 0;
    logic [2:0] done;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame phase t counts cycles since reset; limiter = FP-1-t.
    initial begin
        int         t_m;
        int         ptr_m;
        int         lim;
        int         g;
        int         i;
        logic [2:0] er;
        pix_t       p;
        t_m   = 0;
        ptr_m = 0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            lim = FP - 1 - t_m;
            check("window_open", window_open, lim < WIN);
            check("frame_tick", frame_tick, lim == 0);
            g = -1;
            if (!reset && lim < WIN) begin
                for (int k = 0; k < 3; k++) begin
                    i = (ptr_m + k) % 3;
                    if (g < 0 && req_valid[i]) g = i;
                end
            end
            er = (g >= 0) ? (3'b001 << g) : 3'b000;
            check("req_ready", req_ready, er);
            if (g >= 0) begin
                p.cyc = cyc + 1;
                p.x   = req_x[8*g +: 8];
                p.y   = req_y[7*g +: 7];
                p.c   = req_colour[18*g +: 18];
                exp_q.push_back(p);
                ptr_m = (g + 1) % 3;
            end
            if (reset) begin
                t_m   = 0;
                ptr_m = 0;
            end else begin
                t_m = (t_m + 1) % FP;
            end
        end
    end

    // Monitor: every VGA write must match the oldest predicted pixel in its cycle.
    initial begin
        pix_t p;
        forever begin
            @(negedge clock);
            if (vga_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", vga_write, 1'b0);
                end else begin
                    p = exp_q.pop_front();
                    check("write_cycle", cyc, p.cyc);
                    check("vga_x", vga_x, p.x);
                    check("vga_y", vga_y, p.y);
                    check("vga_colour", vga_colour, p.c);
                end
            end else begin
                check("idle_fields", {vga_x, vga_y, vga_colour}, 33'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    void'(exp_q.pop_front());
                    check("missing_write", vga_write, 1'b1);
                end
            end
        end
    end

    task automatic cycle(input logic rst);
        logic [2:0] mask;
        @(negedge clock);
        done = req_valid & req_ready;
        @(posedge clock);
        #1;
        reset = rst;
        case (mode)
            2:       mask = 3'b111;
            3:       mask = 3'b100;
            4:       mask = 3'b011;
            5:       mask = 3'b111;
            default: mask = 3'b000;
        endcase
        if (mode == 1) begin
            req_valid          = 3'b010;
            req_x[15:8]        = 8'd5;
            req_y[13:7]        = 7'd9;
            req_colour[35:18]  = 18'h3FFFF;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!mask[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] || done[i]) begin
                    req_valid[i]         = (mode == 5) ? 1'($urandom_range(0, 1)) : 1'b1;
                    req_x[8*i +: 8]      = 8'($urandom);
                    req_y[7*i +: 7]      = 7'($urandom);
                    req_colour[18*i +: 18] = 18'($urandom);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 3'b000;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        done       = 3'b000;
        repeat (3) cycle(1'b1);
        repeat (45) cycle(1'b0);

        mode = 1;
        repeat (45) cycle(1'b0);

        mode = 2;
        cycle(1'b1);
        repeat (25) cycle(1'b0);

        mode = 3;
        cycle(1'b1);
        repeat (30) cycle(1'b0);

        // Assert reset in the first window cycle with requesters 0 and 1 pending.
        mode = 4;
        cycle(1'b1);
        cycle(1'b0);
        for (int k = 0; k < 40 && !window_open; k++) cycle(1'b0);
        if (!window_open) check("window_reached", window_open, 1'b1);
        reset = 1'b1;
        repeat (6) cycle(1'b0);

        mode = 5;
        repeat (800) cycle($urandom_range(0, 59) == 0);

        mode = 0;
        repeat (4) cycle(1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
